// File: rtl/bus_dest_bank_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_dest_bank_pkg : shared bus source codes and widths                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package bus_dest_bank_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_SRC    = 24;

  // Bus mux source codes; the bit index of out_strb equals the code.
  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHIGH  = 5'd18;
  localparam logic [4:0] SRC_ZLOW   = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;
  localparam logic [4:0] SRC_NONE   = 5'd31;

endpackage : bus_dest_bank_pkg
`default_nettype wire

// File: rtl/bus_src_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_src_encoder : one-hot source strobes to 5-bit bus mux select      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bus_src_encoder
  import bus_dest_bank_pkg::*;
(
  input  logic [NUM_SRC-1:0] out_strb,
  output logic [4:0]         bus_sel,
  output logic               conflict
);

  logic [4:0] w_count;
  logic [4:0] w_idx;

  always_comb begin
    w_count = 5'd0;
    w_idx   = SRC_NONE;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (out_strb[k]) begin
        w_count = w_count + 5'd1;
        w_idx   = 5'(k);
      end
    end
  end

  // Idle and multi-driver cycles both park the mux on its zero input.
  assign conflict = (w_count > 5'd1);
  assign bus_sel  = (w_count == 5'd1) ? w_idx : SRC_NONE;

endmodule : bus_src_encoder
`default_nettype wire

// File: rtl/bus_dest_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_dest_bank : bus-loaded GPR/HI/LO/Z registers, source encoder,     |
// |                 conflict flag and saturating load counter             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bus_dest_bank
  import bus_dest_bank_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_GPR = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic [DATA_W-1:0]         bus_in,
  input  logic [NUM_GPR-1:0]        gpr_in,
  input  logic                      hi_in,
  input  logic                      lo_in,
  input  logic                      z_in,
  input  logic [2*DATA_W-1:0]       alu_c,
  input  logic                      ba_out,
  input  logic [NUM_SRC-1:0]        out_strb,
  input  logic                      err_clr,
  output logic [NUM_GPR*DATA_W-1:0] gpr_q,
  output logic [DATA_W-1:0]         hi_q,
  output logic [DATA_W-1:0]         lo_q,
  output logic [DATA_W-1:0]         z_hi_q,
  output logic [DATA_W-1:0]         z_lo_q,
  output logic [4:0]                bus_sel,
  output logic                      conflict,
  output logic                      conflict_sticky,
  output logic [CNT_W-1:0]          load_cnt
);

  logic [DATA_W-1:0]   r_gpr [NUM_GPR];
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [2*DATA_W-1:0] r_z;
  logic                r_sticky;
  logic [CNT_W-1:0]    r_loadCnt;
  logic                w_anyLoad;

  generate
    for (genvar i = 0; i < NUM_GPR; i++) begin : g_gpr
      always_ff @(posedge clock) begin
        if (!clear)
          r_gpr[i] <= '0;
        else if (gpr_in[i])
          r_gpr[i] <= bus_in;
      end

      // ba_out masks only the bus view of R0, never its storage.
      if (i == 0) begin : g_r0
        assign gpr_q[i*DATA_W +: DATA_W] = ba_out ? '0 : r_gpr[i];
      end else begin : g_rn
        assign gpr_q[i*DATA_W +: DATA_W] = r_gpr[i];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_hi <= '0;
      r_lo <= '0;
      r_z  <= '0;
    end else begin
      if (hi_in) r_hi <= bus_in;
      if (lo_in) r_lo <= bus_in;
      if (z_in)  r_z  <= alu_c;
    end
  end

  bus_src_encoder u_enc (
    .out_strb (out_strb),
    .bus_sel  (bus_sel),
    .conflict (conflict)
  );

  // A fresh conflict takes priority over err_clr.
  always_ff @(posedge clock) begin
    if (!clear)
      r_sticky <= 1'b0;
    else if (conflict)
      r_sticky <= 1'b1;
    else if (err_clr)
      r_sticky <= 1'b0;
  end

  assign w_anyLoad = (|gpr_in) | hi_in | lo_in | z_in;

  always_ff @(posedge clock) begin
    if (!clear)
      r_loadCnt <= '0;
    else if (w_anyLoad && (r_loadCnt != {CNT_W{1'b1}}))
      r_loadCnt <= r_loadCnt + 1'b1;
  end

  assign hi_q            = r_hi;
  assign lo_q            = r_lo;
  assign z_hi_q          = r_z[2*DATA_W-1:DATA_W];
  assign z_lo_q          = r_z[DATA_W-1:0];
  assign conflict_sticky = r_sticky;
  assign load_cnt        = r_loadCnt;

endmodule : bus_dest_bank
`default_nettype wire

// File: tb/tb_bus_dest_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bus_dest_bank : directed vector bench for bus_dest_bank            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_bus_dest_bank;

  localparam int DW = 32;
  localparam int NG = 16;

  logic          clock = 1'b0;
  logic          clear;
  logic [DW-1:0] bus_in;
  logic [NG-1:0] gpr_in;
  logic          hi_in, lo_in, z_in, ba_out, err_clr;
  logic [2*DW-1:0] alu_c;
  logic [23:0]   out_strb;

  logic [NG*DW-1:0] gprQ, gprQS;
  logic [DW-1:0]    hiQ, loQ, zHiQ, zLoQ, hiQS, loQS, zHiQS, zLoQS;
  logic [4:0]       busSel, busSelS;
  logic             conf, confS, sticky, stickyS;
  logic [15:0]      cnt;
  logic [3:0]       cntS;

  always #5 clock = ~clock;

  bus_dest_bank dut (
    .clock(clock), .clear(clear), .bus_in(bus_in), .gpr_in(gpr_in),
    .hi_in(hi_in), .lo_in(lo_in), .z_in(z_in), .alu_c(alu_c),
    .ba_out(ba_out), .out_strb(out_strb), .err_clr(err_clr),
    .gpr_q(gprQ), .hi_q(hiQ), .lo_q(loQ), .z_hi_q(zHiQ), .z_lo_q(zLoQ),
    .bus_sel(busSel), .conflict(conf), .conflict_sticky(sticky),
    .load_cnt(cnt)
  );

  bus_dest_bank #(.CNT_W(4)) dutSmall (
    .clock(clock), .clear(clear), .bus_in(bus_in), .gpr_in(gpr_in),
    .hi_in(hi_in), .lo_in(lo_in), .z_in(z_in), .alu_c(alu_c),
    .ba_out(ba_out), .out_strb(out_strb), .err_clr(err_clr),
    .gpr_q(gprQS), .hi_q(hiQS), .lo_q(loQS), .z_hi_q(zHiQS), .z_lo_q(zLoQS),
    .bus_sel(busSelS), .conflict(confS), .conflict_sticky(stickyS),
    .load_cnt(cntS)
  );

  typedef struct {
    logic          clr;
    logic [15:0]   gIn;
    logic          hIn, lIn, zIn;
    logic [31:0]   bus;
    logic [63:0]   alu;
    logic          ba;
    logic [23:0]   strb;
    logic          eclr;
    logic [31:0]   eR0, eR5, eHi, eLo, eZh, eZl;
    logic [4:0]    eSel;
    logic          eConf, eSticky;
    logic [15:0]   eCnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  int   applied    = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input int v, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec%0d: got %h expected %h", name, v, act, exp);
      miscompares++;
    end
  endtask

  function automatic logic [31:0] otherGprs(input logic [NG*DW-1:0] g);
    logic [31:0] acc = '0;
    for (int i = 1; i < NG; i++)
      if (i != 5) acc |= g[i*DW +: DW];
    return acc;
  endfunction

  task automatic drive(input vec_t v);
    clear = v.clr; gpr_in = v.gIn; hi_in = v.hIn; lo_in = v.lIn; z_in = v.zIn;
    bus_in = v.bus; alu_c = v.alu; ba_out = v.ba; out_strb = v.strb; err_clr = v.eclr;
  endtask

  initial begin
    //            clr gIn       h  l  z  bus           alu                    ba strb          ec  eR0           eR5           eHi           eLo           eZh           eZl           sel  cf st cnt
    vecs[0]  = '{0, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000000, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 0};
    vecs[1]  = '{1, 16'h0020, 0, 0, 0, 32'hDEADBEEF, 64'h0,                 0, 24'h000000, 0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 1};
    vecs[2]  = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000020, 0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        5,  0, 0, 1};
    vecs[3]  = '{1, 16'h0001, 0, 0, 0, 32'h12345678, 64'h0,                 0, 24'h000000, 0, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 2};
    vecs[4]  = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 1, 24'h000000, 0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 2};
    vecs[5]  = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000000, 0, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 2};
    vecs[6]  = '{1, 16'h0001, 0, 0, 0, 32'hCAFEF00D, 64'h0,                 1, 24'h000000, 0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 3};
    vecs[7]  = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000000, 0, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 3};
    vecs[8]  = '{1, 16'h0000, 0, 0, 1, 32'h0,        64'h00000001FFFFFFFE,  0, 24'h000000, 0, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0,        32'h0,        32'h1,        32'hFFFFFFFE, 31, 0, 0, 4};
    vecs[9]  = '{1, 16'h0000, 1, 1, 0, 32'hA5A5A5A5, 64'h0,                 0, 24'h000000, 0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE, 31, 0, 0, 5};
    vecs[10] = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h200008, 0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE, 31, 1, 1, 5};
    vecs[11] = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h200008, 1, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE, 31, 1, 1, 5};
    vecs[12] = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000000, 1, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE, 31, 0, 0, 5};
    vecs[13] = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h800000, 0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE, 23, 0, 0, 5};
    vecs[14] = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000001, 0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE, 0,  0, 0, 5};
    vecs[15] = '{0, 16'hFFFF, 1, 1, 1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,  0, 24'h030000, 1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        31, 1, 0, 0};
    vecs[16] = '{1, 16'h0000, 0, 0, 0, 32'h0,        64'h0,                 0, 24'h000000, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        31, 0, 0, 0};

    drive(vecs[0]);
    for (int v = 0; v < NV; v++) begin
      drive(vecs[v]);
      @(posedge clock); #1;
      applied++;
      chk("r0",      v, 64'(gprQ[0 +: DW]),    64'(vecs[v].eR0));
      chk("r5",      v, 64'(gprQ[5*DW +: DW]), 64'(vecs[v].eR5));
      chk("rest",    v, 64'(otherGprs(gprQ)),  64'h0);
      chk("hi",      v, 64'(hiQ),    64'(vecs[v].eHi));
      chk("lo",      v, 64'(loQ),    64'(vecs[v].eLo));
      chk("zhi",     v, 64'(zHiQ),   64'(vecs[v].eZh));
      chk("zlo",     v, 64'(zLoQ),   64'(vecs[v].eZl));
      chk("bus_sel", v, 64'(busSel), 64'(vecs[v].eSel));
      chk("conflict",v, 64'(conf),   64'(vecs[v].eConf));
      chk("sticky",  v, 64'(sticky), 64'(vecs[v].eSticky));
      chk("load_cnt",v, 64'(cnt),    64'(vecs[v].eCnt));
    end

    // Saturation: 15 loads reach the 4-bit ceiling, 5 more must not wrap.
    drive(vecs[16]);
    gpr_in = 16'h0002; bus_in = 32'h0000_0042;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (n == 15 || n == 20) begin
        applied++;
        chk("cnt_small", 100 + n, 64'(cntS), 64'd15);
        chk("cnt_wide",  100 + n, 64'(cnt),  64'(n));
        chk("r1_small",  100 + n, 64'(gprQS[DW +: DW]), 64'h42);
      end
    end
    gpr_in = '0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule : tb_bus_dest_bank
`default_nettype wire

// File: doc/bus_dest_bank.md
Name: bus_dest_bank

Overview:
- Receiving end of the single 32-bit datapath bus. Holds the bus-loaded registers (R0–R15, HI, LO) and the 64-bit Z result register.
- Presents their contents back to the bus source mux.
- Encodes the one-hot "out" strobes from control into the 5-bit source select.
- Sits between the control unit and the bus mux. Also reports illegal multi-driver cycles and counts bus loads for debug.

Parameters:
- DATA_W, 32, bus and register width
- NUM_GPR, 16, general-purpose registers R0..R15
- CNT_W, 16, width of the saturating load counter

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  reset: synchronous and active-low
- bus_in  in  DATA_W  current bus value (mux output)
- gpr_in  in  NUM_GPR  per-GPR load enables (R0in..R15in)
- hi_in  in  1  load HI from bus
- lo_in  in  1  load LO from bus
- z_in  in  1  load Z from alu_c
- alu_c  in  2*DATA_W  ALU result
- ba_out  in  1  R0 reads as zero on bus when high
- out_strb  in  24  one-hot source strobes, bit k = mux code k (0–15 GPR, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C_sign_ext)
- err_clr  in  1  clear sticky conflict flag
- gpr_q  out  NUM_GPR*DATA_W  flattened GPRs; R0 slice gated by ba_out
- hi_q  out  DATA_W  HI contents
- lo_q  out  DATA_W  LO contents
- z_hi_q  out  DATA_W  Z[63:32]
- z_lo_q  out  DATA_W  Z[31:0]
- bus_sel  out  5  select for the bus mux
- conflict  out  1  combinational: more than one out_strb bit high this cycle
- conflict_sticky  out  1  registered sticky conflict flag
- load_cnt  out  CNT_W  saturating count of cycles with any load enable

Behaviour:
- Reset (clear=0 at posedge): all GPRs, HI, LO, Z = 0; conflict_sticky = 0; load_cnt = 0. Reset overrides every load and err_clr in the same cycle.
- Loads:
  - On posedge with clear=1, each register whose enable is high takes bus_in; Z takes alu_c.
  - Multiple destination enables in one cycle are legal (broadcast); all take the same value.
  - Values are visible on the outputs the cycle after the edge, i.e. one-cycle latency.
- R0 gating: the R0 slice of gpr_q is 0 while ba_out=1, combinationally. Stored R0 is unaffected, and R0 can still be loaded while ba_out=1.
- Encoder, fully combinational, same cycle:
  - Exactly one out_strb bit k high: bus_sel = k.
  - Zero bits high: bus_sel = 5'd31 (mux drives 0).
  - Two or more bits high: bus_sel = 5'd31 and conflict = 1.
- Sticky flag:
  - Sets at the posedge when conflict=1.
  - Clears at the posedge when err_clr=1 and conflict=0.
  - A new conflict in the same cycle as err_clr wins, so the flag stays set.
- load_cnt:
  - Increments by 1 per posedge where any of gpr_in, hi_in, lo_in, z_in is high.
  - A broadcast still counts 1.
  - Saturates at all-ones with no wrap.
- bus_sel never takes values 24–30.
- Outputs contain no X after the first reset edge.

Decomposition:
- Shared package:
  - bus source code constants (SRC_R0=0 … SRC_CSIGN=23, SRC_NONE=31)
  - DATA_W default
  - source-count constant 24
- One sub-module, bus_src_encoder: one-hot out_strb to bus_sel plus conflict, purely combinational. Reusable by control-unit tests.
- Register storage stays inline, one generate loop over NUM_GPR.

Test Plan:
- Reset then idle: clear=0 one cycle → all *_q = 0, bus_sel=31, conflict_sticky=0, load_cnt=0.
- bus_in=0xDEADBEEF, gpr_in=16'h0020 one cycle → next cycle R5 slice=0xDEADBEEF, others 0, load_cnt=1. Then out_strb bit 5 → bus_sel=5.
- R0 gating: load R0=0x12345678, then ba_out=1 → R0 slice reads 0. ba_out=0 → reads 0x12345678.
- z_in=1, alu_c=0x00000001_FFFFFFFE → z_hi_q=0x00000001, z_lo_q=0xFFFFFFFE.
- out_strb bits 3 and 21 together → bus_sel=31, conflict=1, sticky=1 next cycle. Then err_clr with the conflict repeated → sticky stays 1. Then err_clr alone → sticky=0.
- clear=0 in the same cycle as gpr_in=all-ones, bus_in=0xFFFFFFFF → all GPRs 0, load_cnt=0. Then force CNT_W=4 and apply 20 load cycles → load_cnt=15.
